decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL expose parameter XLEN, default 32, datapath width (32 or 64) of pc and immediate outputs.
REQ-002 SHALL expose parameter BRANCH_EN, default 1, enables B-type (opcode 1100011) decode; when 0 the opcode is illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch offers instruction; in_ready  output  1  stage can accept.
REQ-006 instruction  input  32  raw RV instruction; pc_in  input  XLEN  its address.
REQ-007 flush  input  1  discard held and incoming instruction.
REQ-008 out_valid  output  1  decoded bundle valid; out_ready  input  1  execute accepts.
REQ-009 pc_out  output  XLEN; imm  output  XLEN; rs1, rs2, rd  output  5 each.
REQ-010 regWrite, memToReg, memWrite, operandA, operandB, branch, jalrEN, jalEN, illegal  output  1 each; aluOP  output  6; brFunc3  output  3.

Function
REQ-011 Outputs SHALL be registered; latency in_valid&in_ready to out_valid = 1 cycle.
REQ-012 in_ready SHALL equal !out_valid || out_ready (combinational, no bubble at full throughput).
REQ-013 Transfer on input side iff in_valid&in_ready; output held stable while out_valid&!out_ready.
REQ-014 Simultaneous output accept and input accept SHALL load new bundle same edge, out_valid stays 1.
REQ-015 Output accept without input accept SHALL clear out_valid next edge.
REQ-016 flush SHALL clear out_valid next edge and block capture that cycle regardless of in_valid; flush has priority over all.
REQ-017 Immediates SHALL be sign-extended to XLEN: I-type (0000011, 0010011, 1100111), S (0100011), B {inst[31],inst[7],inst[30:25],inst[11:8],0}, U {inst[31:12],12'b0} sign-extended, J {inst[31],inst[19:12],inst[20],inst[30:21],0}; other opcodes imm=0.
REQ-018 aluOP encodings SHALL be: loads 0-4 (LB,LH,LW,LD,LBU), I-ALU 5-13 (SRAI 11 vs SRLI 10 by inst[30]), AUIPC 14, stores 15-17, R-ALU 18-27 (SUB 19 vs ADD 18, SRA 25 vs SRL 24 by inst[30]), LUI 28, BEQ/BNE/BLT/BGE/BLTU/BGEU 29-34, JALR 35, JAL 36.
REQ-019 Control bits per opcode: R: regWrite; I-ALU: regWrite,operandA; load: regWrite,memToReg,operandA; JALR: regWrite,operandA,jalrEN; store: memWrite,operandA; AUIPC/JAL: regWrite,operandA,operandB (+jalEN for JAL); LUI: regWrite,operandA; B: branch,operandB, brFunc3=inst[14:12].
REQ-020 illegal SHALL be 1 for unlisted opcodes, load func3 5-7, store func3 3-7 (func3 3 when XLEN=32), branch func3 2-3, LD when XLEN=32; illegal bundles SHALL have all other control bits 0 and aluOP 0.
REQ-021 rd SHALL read 0 for store and branch; rs2 SHALL read 0 for I, U, J types.

Reset
REQ-022 On rst_n low all outputs except in_ready SHALL be 0 asynchronously; in_ready=1 during and after reset.
REQ-023 Reset mid-stall SHALL drop the held bundle; first capture allowed on first edge after rst_n deasserts.

Structure
REQ-024 Opcode constants, aluOP codes and XLEN legality checks SHALL live in shared package rv_decode_pkg.
REQ-025 Combinational decode SHALL be a sub-module decode_comb feeding the registered handshake stage.

Verification
REQ-026 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle rd=1, rs1=0, imm=5, aluOP=5, regWrite=operandA=1.
REQ-027 0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, aluOP=29, branch=1, brFunc3=0, rd=0; BRANCH_EN=0 -> illegal=1.
REQ-028 0x402081B3 (sub x3,x1,x2) with out_ready=0 for 3 cycles -> bundle aluOP=19 held stable, in_ready=0, then released on out_ready=1.
REQ-029 0x0000007F -> illegal=1, all controls 0; XLEN=64 with 0x0000B083 (ld) -> aluOP=3, illegal=0; XLEN=32 -> illegal=1.
REQ-030 Back-to-back stream, flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, neither instruction appears; rst_n pulse mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV decode definitions: opcodes, aluOP code points, legality helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rv_decode_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // aluOP code points; each group is a base plus an offset derived from funct3
   localparam logic [5:0] ALU_LOAD_BASE  = 6'd0;
   localparam logic [5:0] ALU_IMM_BASE   = 6'd5;
   localparam logic [5:0] ALU_AUIPC      = 6'd14;
   localparam logic [5:0] ALU_STORE_BASE = 6'd15;
   localparam logic [5:0] ALU_REG_BASE   = 6'd18;
   localparam logic [5:0] ALU_LUI        = 6'd28;
   localparam logic [5:0] ALU_BR_BASE    = 6'd29;
   localparam logic [5:0] ALU_JALR       = 6'd35;
   localparam logic [5:0] ALU_JAL        = 6'd36;

   localparam logic [2:0] F3_LD = 3'd3;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       operand_a;
      logic       operand_b;
      logic       branch;
      logic       jalr_en;
      logic       jal_en;
      logic       illegal;
      logic [5:0] alu_op;
      logic [2:0] br_func3;
   } ctrl_t;

   // LB/LH/LW/LD/LBU only; LD needs a 64-bit datapath
   function automatic logic load_legal(input logic [2:0] f3, input int xlen);
      return (f3 <= 3'd4) && !((f3 == F3_LD) && (xlen == 32));
   endfunction

   // SB/SH/SW only
   function automatic logic store_legal(input logic [2:0] f3);
      return f3 <= 3'd2;
   endfunction

   function automatic logic branch_legal(input logic [2:0] f3);
      return (f3 != 3'd2) && (f3 != 3'd3);
   endfunction

   // ADDI..ANDI in funct3 order, with SRAI slotted directly after SRLI
   function automatic logic [5:0] alu_imm_op(input logic [2:0] f3, input logic alt);
      return ALU_IMM_BASE + 6'(f3) + 6'(f3 > 3'd5) + 6'((f3 == 3'd5) && alt);
   endfunction

   // ADD,SUB,SLL..XOR,SRL,SRA,OR,AND: SUB follows ADD, SRA follows SRL
   function automatic logic [5:0] alu_reg_op(input logic [2:0] f3, input logic alt);
      return ALU_REG_BASE + 6'(f3) + 6'(f3 != 3'd0) + 6'(f3 > 3'd5)
             + 6'(((f3 == 3'd0) || (f3 == 3'd5)) && alt);
   endfunction

   // BEQ,BNE then BLT..BGEU; funct3 2/3 are holes in the encoding
   function automatic logic [5:0] alu_br_op(input logic [2:0] f3);
      return ALU_BR_BASE + ((f3 < 3'd4) ? 6'(f3) : (6'(f3) - 6'd2));
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV instruction decoder producing control, immediate and register fields.
// Latency: 0 cycles (combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
// Ports: instruction in; ctrl (control bundle), imm (sign-extended to XLEN), rs1/rs2/rd out.
module decode_comb
   import rv_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit BRANCH_EN = 1'b1
) (
   input  logic [31:0]     instruction,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic        alt;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] imm32;

   assign opc = instruction[6:0];
   assign f3  = instruction[14:12];
   assign alt = instruction[30];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {instruction[31:12], 12'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   // the 32-bit immediate is already sign-correct; widen it preserving the sign
   assign imm = XLEN'($signed(imm32));

   always_comb begin
      ctrl  = '0;
      imm32 = '0;
      rs1   = instruction[19:15];
      rs2   = instruction[24:20];
      rd    = instruction[11:7];
      case (opc)
         OPC_LOAD: begin
            imm32 = imm_i;
            rs2   = '0;
            if (load_legal(f3, XLEN)) begin
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.operand_a  = 1'b1;
               ctrl.alu_op     = ALU_LOAD_BASE + 6'(f3);
            end else begin
               ctrl.illegal = 1'b1;
            end
         end
         OPC_OPIMM: begin
            imm32          = imm_i;
            rs2            = '0;
            ctrl.reg_write = 1'b1;
            ctrl.operand_a = 1'b1;
            ctrl.alu_op    = alu_imm_op(f3, alt);
         end
         OPC_JALR: begin
            imm32          = imm_i;
            rs2            = '0;
            ctrl.reg_write = 1'b1;
            ctrl.operand_a = 1'b1;
            ctrl.jalr_en   = 1'b1;
            ctrl.alu_op    = ALU_JALR;
         end
         OPC_STORE: begin
            imm32 = imm_s;
            rd    = '0;
            if (store_legal(f3)) begin
               ctrl.mem_write = 1'b1;
               ctrl.operand_a = 1'b1;
               ctrl.alu_op    = ALU_STORE_BASE + 6'(f3);
            end else begin
               ctrl.illegal = 1'b1;
            end
         end
         OPC_OP: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = alu_reg_op(f3, alt);
         end
         OPC_LUI: begin
            imm32          = imm_u;
            rs2            = '0;
            ctrl.reg_write = 1'b1;
            ctrl.operand_a = 1'b1;
            ctrl.alu_op    = ALU_LUI;
         end
         OPC_AUIPC: begin
            imm32          = imm_u;
            rs2            = '0;
            ctrl.reg_write = 1'b1;
            ctrl.operand_a = 1'b1;
            ctrl.operand_b = 1'b1;
            ctrl.alu_op    = ALU_AUIPC;
         end
         OPC_JAL: begin
            imm32          = imm_j;
            rs2            = '0;
            ctrl.reg_write = 1'b1;
            ctrl.operand_a = 1'b1;
            ctrl.operand_b = 1'b1;
            ctrl.jal_en    = 1'b1;
            ctrl.alu_op    = ALU_JAL;
         end
         OPC_BRANCH: begin
            // with branches compiled out this opcode is treated like any unknown one
            if (BRANCH_EN) begin
               imm32 = imm_b;
               rd    = '0;
               if (branch_legal(f3)) begin
                  ctrl.branch    = 1'b1;
                  ctrl.operand_b = 1'b1;
                  ctrl.br_func3  = f3;
                  ctrl.alu_op    = alu_br_op(f3);
               end else begin
                  ctrl.illegal = 1'b1;
               end
            end else begin
               ctrl.illegal = 1'b1;
            end
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV decode stage: decodes a fetched instruction into a control bundle for execute.
// Latency: 1 cycle from in_valid&in_ready to out_valid.
// Backpressure: valid/ready; bundle held while out_valid&!out_ready, in_ready = !out_valid || out_ready.
// Ports: clk/rst_n; in_valid/in_ready/instruction/pc_in from fetch; flush; out_valid/out_ready and
//        pc_out, imm, rs1/rs2/rd plus per-bit control, aluOP and brFunc3 to execute.
module decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit BRANCH_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            regWrite,
   output logic            memToReg,
   output logic            memWrite,
   output logic            operandA,
   output logic            operandB,
   output logic            branch,
   output logic            jalrEN,
   output logic            jalEN,
   output logic            illegal,
   output logic [5:0]      aluOP,
   output logic [2:0]      brFunc3
);

   ctrl_t           dec_ctrl;
   ctrl_t           ctrl_q;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [4:0]      dec_rd;
   logic            take;

   decode_comb #(
      .XLEN      (XLEN),
      .BRANCH_EN (BRANCH_EN)
   ) u_decode_comb (
      .instruction (instruction),
      .ctrl        (dec_ctrl),
      .imm         (dec_imm),
      .rs1         (dec_rs1),
      .rs2         (dec_rs2),
      .rd          (dec_rd)
   );

   // an empty or draining slot can take a new instruction in the same cycle
   assign in_ready = !out_valid || out_ready;
   assign take     = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         pc_out    <= '0;
         imm       <= '0;
         rs1       <= '0;
         rs2       <= '0;
         rd        <= '0;
         ctrl_q    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (take) begin
         out_valid <= 1'b1;
         pc_out    <= pc_in;
         imm       <= dec_imm;
         rs1       <= dec_rs1;
         rs2       <= dec_rs2;
         rd        <= dec_rd;
         ctrl_q    <= dec_ctrl;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign regWrite = ctrl_q.reg_write;
   assign memToReg = ctrl_q.mem_to_reg;
   assign memWrite = ctrl_q.mem_write;
   assign operandA = ctrl_q.operand_a;
   assign operandB = ctrl_q.operand_b;
   assign branch   = ctrl_q.branch;
   assign jalrEN   = ctrl_q.jalr_en;
   assign jalEN    = ctrl_q.jal_en;
   assign illegal  = ctrl_q.illegal;
   assign aluOP    = ctrl_q.alu_op;
   assign brFunc3  = ctrl_q.br_func3;

endmodule
